// File: rtl/mux_nx1_sync.sv
// Registered N-to-1 channel multiplexer with a blanked, glitch-free select switch.
// Build option: define MUX_HOLD_LAST_EN to hold the previous channel's data while blanking (default: drive zero).
module mux_nx1_sync #(
    parameter  int WIDTH        = 3,
    parameter  int CHANNELS     = 2,
    localparam int SELW         = $clog2(CHANNELS),
    parameter  int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]           sel,
    input  logic                      sel_load,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      busy,
    output logic [SELW-1:0]           cur_sel,
    output logic                      sel_err
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] BLANK = 1'b1;

    // cnt counts down to zero, so a B-cycle blank loads B-1.
    localparam logic [7:0] BLANK_INIT = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;
    localparam bit         ZERO_BLANK = (BLANK_CYCLES == 0);
    localparam logic [SELW:0] CH_LIMIT = (SELW + 1)'(CHANNELS);

    function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] s,
                                              input logic [CHANNELS*WIDTH-1:0] d);
        pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (s == k[SELW-1:0]) pick = d[k*WIDTH +: WIDTH];
        end
    endfunction

    function automatic logic sel_in_range(input logic [SELW-1:0] s);
        sel_in_range = ({1'b0, s} < CH_LIMIT);
    endfunction

    logic [0:0]       state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [SELW-1:0]  cur_n;
    logic [WIDTH-1:0] data_p1, data_n;
    logic             vld_p1, vld_n;
    logic             err_p1, err_n;
    logic [WIDTH-1:0] live;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur_sel;
        data_n  = data_p1;
        vld_n   = vld_p1;
        err_n   = 1'b0;
        live    = pick(cur_sel, in_data);

        case (state)
            RUN: begin
                data_n = live;
                vld_n  = 1'b1;
                if (sel_load) begin
                    if (!sel_in_range(sel)) begin
                        err_n = 1'b1;
                    end else if (sel != cur_sel) begin
                        cur_n = sel;
                        if (ZERO_BLANK) begin
                            data_n = pick(sel, in_data);
                        end else begin
                            state_n = BLANK;
                            cnt_n   = BLANK_INIT;
                            vld_n   = 1'b0;
`ifdef MUX_HOLD_LAST_EN
                            data_n  = data_p1;
`else
                            data_n  = '0;
`endif
                        end
                    end
                end
            end
            default: begin
                // Loads are refused for the whole blank, including its last cycle.
                err_n = sel_load;
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    state_n = RUN;
                    data_n  = live;
                    vld_n   = 1'b1;
                end
            end
        endcase
    end

    // Output stage p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            cnt     <= 8'd0;
            cur_sel <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cur_sel <= cur_n;
            data_p1 <= data_n;
            vld_p1  <= vld_n;
            err_p1  <= err_n;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign busy      = (state == BLANK);
    assign sel_err   = err_p1;

endmodule

// File: tb/tb_mux_nx1_sync.sv
// Bench for mux_nx1_sync: four configurations, fixed vector table, directed corners, random run against a cycle-index model.
module tb_mux_nx1_sync;

`ifdef MUX_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int W    [4] = '{3, 3, 3, 16};
    int C    [4] = '{2, 3, 3, 5};
    int B    [4] = '{2, 2, 0, 3};
    int SELB [4] = '{1, 2, 2, 3};

    logic [79:0] din   [4];
    logic [2:0]  dsel  [4];
    logic        dload [4];
    logic [15:0] dout  [4];
    logic        dvalid[4], dbusy[4], derr[4];
    logic [2:0]  dcur  [4];

    logic [2:0]  a_out, b_out, c_out;
    logic [15:0] d_out;
    logic [0:0]  a_cur;
    logic [1:0]  b_cur, c_cur;
    logic [2:0]  d_cur;
    logic a_v, b_v, c_v, d_v, a_b, b_b, c_b, d_b, a_e, b_e, c_e, d_e;

    mux_nx1_sync #(.WIDTH(3), .CHANNELS(2), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(din[0][5:0]), .sel(dsel[0][0:0]), .sel_load(dload[0]),
        .out_data(a_out), .out_valid(a_v), .busy(a_b), .cur_sel(a_cur), .sel_err(a_e));
    mux_nx1_sync #(.WIDTH(3), .CHANNELS(3), .BLANK_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(din[1][8:0]), .sel(dsel[1][1:0]), .sel_load(dload[1]),
        .out_data(b_out), .out_valid(b_v), .busy(b_b), .cur_sel(b_cur), .sel_err(b_e));
    mux_nx1_sync #(.WIDTH(3), .CHANNELS(3), .BLANK_CYCLES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(din[2][8:0]), .sel(dsel[2][1:0]), .sel_load(dload[2]),
        .out_data(c_out), .out_valid(c_v), .busy(c_b), .cur_sel(c_cur), .sel_err(c_e));
    mux_nx1_sync #(.WIDTH(16), .CHANNELS(5), .BLANK_CYCLES(3)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_data(din[3][79:0]), .sel(dsel[3][2:0]), .sel_load(dload[3]),
        .out_data(d_out), .out_valid(d_v), .busy(d_b), .cur_sel(d_cur), .sel_err(d_e));

    always_comb begin
        dout[0] = 16'(a_out); dout[1] = 16'(b_out); dout[2] = 16'(c_out); dout[3] = d_out;
        dvalid[0] = a_v; dvalid[1] = b_v; dvalid[2] = c_v; dvalid[3] = d_v;
        dbusy[0] = a_b; dbusy[1] = b_b; dbusy[2] = c_b; dbusy[3] = d_b;
        derr[0] = a_e; derr[1] = b_e; derr[2] = c_e; derr[3] = d_e;
        dcur[0] = 3'(a_cur); dcur[1] = 3'(b_cur); dcur[2] = 3'(c_cur); dcur[3] = d_cur;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int k, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, k, $time, got, exp);
        end
    endtask

    // Model: a switch accepted at edge t makes edges t+1..t+B blank-state edges;
    // outputs are blanked after edges t..t+B-1 and fresh after edge t+B.
    int          cyc;
    int          m_cur  [4];
    int          m_bend [4];
    logic [15:0] m_out  [4];
    bit          m_valid[4], m_busy[4], m_err[4];

    function automatic logic [15:0] chan(input int k, input int c);
        logic [79:0] t;
        logic [16:0] m;
        t = din[k] >> (c * W[k]);
        m = (17'd1 << W[k]) - 17'd1;
        return t[15:0] & m[15:0];
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            m_cur[k] = 0; m_bend[k] = -1; m_out[k] = '0;
            m_valid[k] = 0; m_busy[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input int e);
        int s;
        s = int'(dsel[k]);
        m_err[k] = 0;
        if (e <= m_bend[k]) begin
            if (dload[k]) m_err[k] = 1;
            if (e == m_bend[k]) m_out[k] = chan(k, m_cur[k]);
        end else if (dload[k] && s >= C[k]) begin
            m_err[k] = 1;
            m_out[k] = chan(k, m_cur[k]);
        end else if (dload[k] && s != m_cur[k]) begin
            m_cur[k] = s;
            if (B[k] == 0) m_out[k] = chan(k, s);
            else begin
                m_bend[k] = e + B[k];
                if (!HOLD) m_out[k] = '0;
            end
        end else begin
            m_out[k] = chan(k, m_cur[k]);
        end
        m_busy[k]  = (e < m_bend[k]);
        m_valid[k] = !m_busy[k];
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk("out_data", k, int'(dout[k]), int'(m_out[k]));
            chk("out_valid", k, int'(dvalid[k]), int'(m_valid[k]));
            chk("busy", k, int'(dbusy[k]), int'(m_busy[k]));
            chk("cur_sel", k, int'(dcur[k]), m_cur[k]);
            chk("sel_err", k, int'(derr[k]), int'(m_err[k]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_out"}, k, int'(dout[k]), 0);
            chk({tag, "_valid"}, k, int'(dvalid[k]), 0);
            chk({tag, "_busy"}, k, int'(dbusy[k]), 0);
            chk({tag, "_cur"}, k, int'(dcur[k]), 0);
            chk({tag, "_err"}, k, int'(derr[k]), 0);
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 4; k++) model_step(k, cyc);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic do_reset(input bit async_chk);
        rst_n = 1'b0;
        #1;
        if (async_chk) check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       load;
        logic [2:0] sel;
        logic [2:0] zout;
        logic [2:0] hout;
        logic       valid;
        logic       busy;
        logic       err;
        logic [2:0] cur;
    } vec_t;

    vec_t tbl [12];
    int   seq [5] = '{1, 2, 3, 4, 0};

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Channel-0 = 3'b101, channel-1 = 3'b010 for dut_a.
        tbl[0]  = '{1'b0, 3'd0, 3'b101, 3'b101, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 3'd0, 3'b101, 3'b101, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 3'd1, 3'b000, 3'b101, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[3]  = '{1'b0, 3'd0, 3'b000, 3'b101, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{1'b0, 3'd0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[5]  = '{1'b1, 3'd1, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[6]  = '{1'b1, 3'd0, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[7]  = '{1'b1, 3'd1, 3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[8]  = '{1'b0, 3'd0, 3'b101, 3'b101, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[9]  = '{1'b1, 3'd1, 3'b000, 3'b101, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[10] = '{1'b0, 3'd0, 3'b000, 3'b101, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[11] = '{1'b0, 3'd0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'd1};

        for (int k = 0; k < 4; k++) begin
            din[k]   = {16'($urandom()), $urandom(), $urandom()};
            dsel[k]  = 3'd0;
            dload[k] = 1'b0;
        end
        din[0] = 80'(6'b010_101);
        model_reset();
        do_reset(1'b0);

        for (int i = 0; i < 12; i++) begin
            dload[0] = tbl[i].load;
            dsel[0]  = tbl[i].sel;
            tick();
            chk("tbl_out", 0, int'(dout[0]), int'(HOLD ? tbl[i].hout : tbl[i].zout));
            chk("tbl_valid", 0, int'(dvalid[0]), int'(tbl[i].valid));
            chk("tbl_busy", 0, int'(dbusy[0]), int'(tbl[i].busy));
            chk("tbl_err", 0, int'(derr[0]), int'(tbl[i].err));
            chk("tbl_cur", 0, int'(dcur[0]), int'(tbl[i].cur));
        end
        dload[0] = 1'b0;

        // Out-of-range select in RUN on the 3-channel build.
        dload[1] = 1'b1; dsel[1] = 3'd3;
        tick();
        chk("rej_err", 1, int'(derr[1]), 1);
        chk("rej_cur", 1, int'(dcur[1]), 0);
        chk("rej_valid", 1, int'(dvalid[1]), 1);
        dload[1] = 1'b0;
        tick();
        chk("rej_err_clear", 1, int'(derr[1]), 0);

        // Zero-blank switch keeps out_valid high.
        dload[2] = 1'b1; dsel[2] = 3'd1;
        tick();
        dload[2] = 1'b0;
        chk("zb_valid", 2, int'(dvalid[2]), 1);
        chk("zb_busy", 2, int'(dbusy[2]), 0);
        chk("zb_cur", 2, int'(dcur[2]), 1);
        chk("zb_out", 2, int'(dout[2]), int'(chan(2, 1)));

        // Async reset in the middle of a blank.
        dload[0] = 1'b1; dsel[0] = 3'd0;
        tick();
        dload[0] = 1'b0;
        chk("pre_rst_busy", 0, int'(dbusy[0]), 1);
        do_reset(1'b1);
        tick();
        chk("post_rst_out", 0, int'(dout[0]), 5);
        chk("post_rst_valid", 0, int'(dvalid[0]), 1);

        // Walk the 5-channel build through every channel.
        for (int i = 0; i < 5; i++) begin
            int n;
            din[3] = {16'($urandom()), $urandom(), $urandom()};
            dload[3] = 1'b1; dsel[3] = 3'(seq[i]);
            tick();
            dload[3] = 1'b0;
            n = 0;
            while (dbusy[3] && n < 300) begin
                n++;
                tick();
            end
            chk("blank_len", 3, n, B[3]);
            chk("route", 3, int'(dout[3]), int'(chan(3, seq[i])));
            chk("route_valid", 3, int'(dvalid[3]), 1);
        end

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                din[k]   = {16'($urandom()), $urandom(), $urandom()};
                dload[k] = ($urandom_range(0, 3) == 0);
                dsel[k]  = 3'($urandom_range(0, (1 << SELB[k]) - 1));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_nx1_sync.md
# mux_nx1_sync

Registered, parametrised N-to-1 multiplexer of WIDTH-bit channels with a glitch-free channel switch sequence. It generalises the team's 2-to-1 bitwise steering muxes to any channel count and width. The select is held in a register and changed only through a load strobe. A configurable blanking interval marks the output invalid while the source changes. It sits between several same-width data sources and a single downstream consumer that qualifies data with `out_valid`.

## Interface
- `WIDTH`, 3: bits per channel, ≥1
- `CHANNELS`, 2: number of input channels, ≥2
- `SELW`, $clog2(CHANNELS): select width, derived, not overridden
- `BLANK_CYCLES`, 2: blanking cycles on a channel switch, 0–255

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `sel`  in  SELW  requested channel, sampled only when `sel_load`=1
- `sel_load`  in  1  select-change strobe, one-cycle pulse or level
- `out_data`  out  WIDTH  registered selected channel data
- `out_valid`  out  1  `out_data` is from the current channel
- `busy`  out  1  switch in progress (BLANK state)
- `cur_sel`  out  SELW  currently active channel
- `sel_err`  out  1  one-cycle pulse: rejected load request

## Operation
- States: RUN and BLANK. There is an 8-bit blank counter `cnt`.
- Reset (async, `rst_n`=0) sets: state RUN, `cur_sel`=0, `out_data`=0, `out_valid`=0, `busy`=0, `sel_err`=0, `cnt`=0.
- RUN, no load: each edge sets `out_data` ← `in_data[cur_sel]` and `out_valid` ← 1.
- RUN, `sel_load`=1 with `sel` ≥ CHANNELS: request rejected. `sel_err`=1 for one cycle. Data path behaves as in the no-load case.
- RUN, `sel_load`=1 with `sel`==`cur_sel`: no-op. No blanking, no error.
- RUN, `sel_load`=1 with a valid, different `sel`, and BLANK_CYCLES=0:
  - `cur_sel` ← `sel`.
  - Same edge: `out_data` ← `in_data[sel]`, `out_valid` stays 1, `busy` stays 0.
- RUN, `sel_load`=1 with a valid, different `sel`, and BLANK_CYCLES>0:
  - `cur_sel` ← `sel`, state ← BLANK, `cnt` ← BLANK_CYCLES−1.
  - `busy` ← 1, `out_valid` ← 0, `out_data` ← blank value (see Configuration).
- BLANK, `cnt`>0: `cnt` decrements. Outputs are held.
- BLANK, `cnt`==0:
  - state ← RUN, `busy` ← 0.
  - `out_data` ← `in_data[cur_sel]`, `out_valid` ← 1.
- Any `sel_load` while in BLANK is ignored. It pulses `sel_err`. `cur_sel` and `cnt` are unchanged.
- `sel_err` is registered and clears on the following edge unless a new rejection occurs.
- No arithmetic beyond `cnt` decrement. `cnt` never wraps: it is only decremented when nonzero.

## Timing
- Data latency in RUN is one cycle: `in_data` sampled at edge t appears on `out_data` after edge t.
- Switch at edge t (BLANK_CYCLES=B>0):
  - `out_valid`=0 and `busy`=1 for exactly B cycles, after edges t through t+B−1.
  - First new-channel data is valid after edge t+B.
- `cur_sel` updates after edge t, the same edge the load is accepted.
- Back-to-back: a load on the cycle `busy` falls (state is RUN again) is accepted normally.
- Reset asserted mid-BLANK returns all outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- `MUX_HOLD_LAST_EN` defined:
  - During BLANK, `out_data` holds the last value from the previous channel.
  - `out_valid` still drops.
- `MUX_HOLD_LAST_EN` undefined:
  - `out_data` is forced to 0 on entry to BLANK and stays 0 until BLANK exits.
- Neither setting affects `busy`, `cur_sel` or `sel_err` timing.

## Test plan
- Reset then steady run, with WIDTH=3, CHANNELS=2, ch0=3'b101, ch1=3'b010:
  - Release `rst_n` → `out_data`=3'b101 and `out_valid`=1 after the first edge.
  - `cur_sel`=0.
- Switch 0→1 with B=2:
  - `sel_load`=1 with `sel`=1 at edge t → `busy`=1 and `out_valid`=0 after edges t and t+1.
  - After edge t+2: `out_data`=3'b010, `out_valid`=1, `busy`=0.
  - Blank value checked with the macro on (3'b101) and off (3'b000).
- Rejections with CHANNELS=3, SELW=2:
  - `sel`=3 in RUN → one-cycle `sel_err`, `cur_sel` unchanged.
  - A load during BLANK → `sel_err` pulse, original switch completes on schedule.
- Same-select and zero-blank:
  - `sel`==`cur_sel` → no `busy`, no `out_valid` drop.
  - With BLANK_CYCLES=0, a switch yields new data after one edge with `out_valid` continuously 1.
- Async reset mid-BLANK:
  - Drop `rst_n` between edges → all outputs 0 with no clock edge, `cur_sel`=0.
  - After release, normal RUN on ch0.
- Wide config, WIDTH=16, CHANNELS=5, random data:
  - Sequential switches to every channel → each channel's bits routed correctly.
  - Blank lengths match B exactly.
